bubble_page_shifter: RTL and testbench

Parametrised, double-buffered page shifter that sits between the SPI page loader and the bubble data output pins of the emulator core. It generalises the current fixed 1-bit/4-bit output path to NCH parallel output channels and a configurable page length, and uses two page banks so the loader can fill page N+1 while page N drains. It detects and flags underrun (page requested before it is loaded) and protocol errors, and outputs a defined idle level in those cases.

---
 rtl/bubble_pkg.sv | 15 +
 rtl/bubble_bank_ram.sv | 46 ++++
 rtl/bubble_page_shifter.sv | 173 +++++++++++++++++
 tb/tb_bubble_page_shifter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bubble_pkg.sv
// Shared definitions for the double-buffered bubble page shifter:
// the per-bank state, the channel-field width and the idle output level.
package bubble_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FULL     = 2'd1,
        BANK_DRAINING = 2'd2
    } bank_state_e;

    localparam int   MAX_NCH   = 4;
    localparam int   CH_W      = 2;
    localparam logic IDLE_DOUT = 1'b0;

endpackage

// File: rtl/bubble_bank_ram.sv
// Two-bank page store: one 1-bit RAM per output channel, written a bit at a time
// and read NCH bits wide with a registered (synchronous) read.
module bubble_bank_ram #(
    parameter int NCH     = 4,
    parameter int PAGECYC = 584,
    parameter int ADDRW   = $clog2(PAGECYC)
) (
    input  logic             clk,
    input  logic [NCH-1:0]   wr_en,
    input  logic             wr_bank,
    input  logic [ADDRW-1:0] wr_idx,
    input  logic             wr_data,
    input  logic             rd_en,
    input  logic             rd_bank,
    input  logic [ADDRW-1:0] rd_idx,
    output logic [NCH-1:0]   rd_data
);

    localparam int             DEPTH    = 2 * PAGECYC;
    localparam logic [ADDRW:0] PAGE_OFS = (ADDRW + 1)'(PAGECYC);

    logic [ADDRW:0] wr_addr_s;
    logic [ADDRW:0] rd_addr_s;

    // Bank 1 sits directly above bank 0, so the store is exactly two pages deep.
    assign wr_addr_s = wr_bank ? (PAGE_OFS + {1'b0, wr_idx}) : {1'b0, wr_idx};
    assign rd_addr_s = rd_bank ? (PAGE_OFS + {1'b0, rd_idx}) : {1'b0, rd_idx};

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic mem_r [DEPTH];
        logic rd_q_r;

        // Per-channel storage with write port and registered read port.
        always_ff @(posedge clk) begin
            if (wr_en[c]) begin
                mem_r[wr_addr_s] <= wr_data;
            end
            if (rd_en) begin
                rd_q_r <= mem_r[rd_addr_s];
            end
        end

        assign rd_data[c] = rd_q_r;
    end

endmodule

// File: rtl/bubble_page_shifter.sv
// Double-buffered page shifter: the loader fills one bank while the other drains
// NCH bits per output strobe; underrun and protocol errors are flagged sticky.
module bubble_page_shifter
    import bubble_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int PAGECYC = 584,
    parameter int ADDRW   = $clog2(PAGECYC)
) (
    input  logic             MCLK,
    input  logic             nRST,
    input  logic             nEN,
    input  logic             nWRCLKEN,
    input  logic [ADDRW+1:0] WRADDR,
    input  logic             WRDATA,
    input  logic             nFILLDONE,
    output logic             FILLREQ,
    input  logic             nPAGESTART,
    input  logic             nOUTCLKEN,
    output logic [NCH-1:0]   DOUT,
    output logic             DRAINING,
    output logic             UNDERRUN,
    output logic             PROTERR
);

    localparam logic [ADDRW-1:0] LAST_IDX = ADDRW'(PAGECYC - 1);
    localparam logic [ADDRW:0]   PAGE_LEN = (ADDRW + 1)'(PAGECYC);
    localparam logic [CH_W:0]    NCH_W    = (CH_W + 1)'(NCH);

    bank_state_e      bank_r [2];
    bank_state_e      bank_nxt_s [2];
    logic             fb_r, fb_nxt_s;
    logic             db_r, db_nxt_s;
    logic [ADDRW-1:0] cnt_r, cnt_nxt_s;
    logic             draining_r, draining_nxt_s;
    logic             underrun_r, underrun_nxt_s;
    logic             proterr_r, proterr_nxt_s;
    logic             fillreq_r, fillreq_nxt_s;
    logic             dout_sel_r, dout_sel_nxt_s;
    logic             flush_s;
    logic             rd_en_s;
    logic [ADDRW-1:0] wr_idx_s;
    logic [CH_W-1:0]  wr_ch_s;
    logic             wr_ok_s;
    logic [NCH-1:0]   wr_en_s;
    logic [NCH-1:0]   rd_data_s;

    assign flush_s  = !nRST || nEN;
    assign wr_idx_s = WRADDR[ADDRW+1:CH_W];
    assign wr_ch_s  = WRADDR[CH_W-1:0];
    assign wr_ok_s  = !nWRCLKEN && fillreq_r && !flush_s
                      && ({1'b0, wr_idx_s} < PAGE_LEN) && ({1'b0, wr_ch_s} < NCH_W);

    // One-hot channel select for the write port.
    always_comb begin
        wr_en_s = '0;
        for (int c = 0; c < NCH; c++) begin
            if (wr_ok_s && (wr_ch_s == CH_W'(c))) begin
                wr_en_s[c] = 1'b1;
            end else begin
                wr_en_s[c] = 1'b0;
            end
        end
    end

    // Next-state: fill completion, page start and output strobes are evaluated
    // against the pre-edge state; fill and drain always touch different banks.
    always_comb begin
        bank_nxt_s     = bank_r;
        fb_nxt_s       = fb_r;
        db_nxt_s       = db_r;
        cnt_nxt_s      = cnt_r;
        draining_nxt_s = draining_r;
        underrun_nxt_s = underrun_r;
        proterr_nxt_s  = proterr_r;
        dout_sel_nxt_s = dout_sel_r;
        rd_en_s        = 1'b0;

        if (!nFILLDONE) begin
            if (fillreq_r) begin
                bank_nxt_s[fb_r] = BANK_FULL;
                fb_nxt_s         = !fb_r;
            end else begin
                proterr_nxt_s = 1'b1;
            end
        end else begin
            fb_nxt_s = fb_r;
        end

        if (!nPAGESTART) begin
            if (draining_r) begin
                proterr_nxt_s = 1'b1;
            end else if (bank_r[db_r] == BANK_FULL) begin
                bank_nxt_s[db_r] = BANK_DRAINING;
                draining_nxt_s   = 1'b1;
                cnt_nxt_s        = '0;
            end else begin
                underrun_nxt_s = 1'b1;
            end
        end else begin
            underrun_nxt_s = underrun_r;
        end

        if (!nOUTCLKEN) begin
            dout_sel_nxt_s = draining_r;
            rd_en_s        = draining_r;
            if (draining_r && (cnt_r == LAST_IDX)) begin
                bank_nxt_s[db_r] = BANK_EMPTY;
                db_nxt_s         = !db_r;
                draining_nxt_s   = 1'b0;
                cnt_nxt_s        = '0;
            end else if (draining_r) begin
                cnt_nxt_s = cnt_r + 1'b1;
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end else begin
            dout_sel_nxt_s = dout_sel_r;
        end

        fillreq_nxt_s = (bank_nxt_s[fb_nxt_s] == BANK_EMPTY);
    end

    // State registers; reset and the enable flush clear everything except the RAM.
    always_ff @(posedge MCLK) begin
        if (flush_s) begin
            bank_r[0]  <= BANK_EMPTY;
            bank_r[1]  <= BANK_EMPTY;
            fb_r       <= 1'b0;
            db_r       <= 1'b0;
            cnt_r      <= '0;
            draining_r <= 1'b0;
            underrun_r <= 1'b0;
            proterr_r  <= 1'b0;
            fillreq_r  <= 1'b0;
            dout_sel_r <= 1'b0;
        end else begin
            bank_r     <= bank_nxt_s;
            fb_r       <= fb_nxt_s;
            db_r       <= db_nxt_s;
            cnt_r      <= cnt_nxt_s;
            draining_r <= draining_nxt_s;
            underrun_r <= underrun_nxt_s;
            proterr_r  <= proterr_nxt_s;
            fillreq_r  <= fillreq_nxt_s;
            dout_sel_r <= dout_sel_nxt_s;
        end
    end

    bubble_bank_ram #(
        .NCH     (NCH),
        .PAGECYC (PAGECYC),
        .ADDRW   (ADDRW)
    ) u_ram (
        .clk     (MCLK),
        .wr_en   (wr_en_s),
        .wr_bank (fb_r),
        .wr_idx  (wr_idx_s),
        .wr_data (WRDATA),
        .rd_en   (rd_en_s),
        .rd_bank (db_r),
        .rd_idx  (cnt_r),
        .rd_data (rd_data_s)
    );

    // The RAM read register doubles as the DOUT register; dout_sel_r forces idle.
    assign DOUT     = dout_sel_r ? rd_data_s : {NCH{IDLE_DOUT}};
    assign FILLREQ  = fillreq_r;
    assign DRAINING = draining_r;
    assign UNDERRUN = underrun_r;
    assign PROTERR  = proterr_r;

endmodule

// File: tb/tb_bubble_page_shifter.sv
// Directed-plus-random bench: a page-queue model predicts DOUT and flags for a
// 4-channel/8-cycle instance and a 1-channel/584-cycle instance.
module tb_bubble_page_shifter;

    logic clk;
    logic nrst;

    logic       a_nen, a_nwr, a_wrdata, a_nfd, a_nps, a_noc;
    logic [4:0] a_wraddr;
    logic       a_fillreq, a_drn, a_und, a_prot;
    logic [3:0] a_dout;

    logic        b_nen, b_nwr, b_wrdata, b_nfd, b_nps, b_noc;
    logic [11:0] b_wraddr;
    logic        b_fillreq, b_drn, b_und, b_prot;
    logic [0:0]  b_dout;

    int errors = 0;
    int checks = 0;

    // Model: pages accepted but not yet fully drained, oldest first.
    logic [31:0] pages_q [$];
    logic        und_m;
    logic        prot_m;

    logic [31:0]  pg_v, p_new, drain_pg;
    logic [583:0] bstream;

    bubble_page_shifter #(.NCH(4), .PAGECYC(8)) dut_a (
        .MCLK(clk), .nRST(nrst), .nEN(a_nen), .nWRCLKEN(a_nwr), .WRADDR(a_wraddr),
        .WRDATA(a_wrdata), .nFILLDONE(a_nfd), .FILLREQ(a_fillreq), .nPAGESTART(a_nps),
        .nOUTCLKEN(a_noc), .DOUT(a_dout), .DRAINING(a_drn), .UNDERRUN(a_und), .PROTERR(a_prot)
    );

    bubble_page_shifter #(.NCH(1), .PAGECYC(584)) dut_b (
        .MCLK(clk), .nRST(nrst), .nEN(b_nen), .nWRCLKEN(b_nwr), .WRADDR(b_wraddr),
        .WRDATA(b_wrdata), .nFILLDONE(b_nfd), .FILLREQ(b_fillreq), .nPAGESTART(b_nps),
        .nOUTCLKEN(b_noc), .DOUT(b_dout), .DRAINING(b_drn), .UNDERRUN(b_und), .PROTERR(b_prot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write_page(input logic [31:0] pg);
        for (int i = 0; i < 32; i++) begin
            a_nwr    = 1'b0;
            a_wraddr = 5'(i);
            a_wrdata = pg[i];
            tick();
        end
        a_nwr = 1'b1;
    endtask

    task automatic a_fill_done(input logic [31:0] pg);
        if (pages_q.size() < 2) begin
            pages_q.push_back(pg);
        end else begin
            prot_m = 1'b1;
        end
        a_nfd = 1'b0;
        tick();
        a_nfd = 1'b1;
        check("filldone_fillreq", 32'(a_fillreq), 32'(pages_q.size() < 2));
        check("filldone_proterr", 32'(a_prot), 32'(prot_m));
    endtask

    task automatic a_drain(input bit mid_start);
        logic [31:0] pg;
        pg = pages_q.pop_front();
        a_nps = 1'b0;
        tick();
        a_nps = 1'b1;
        check("drain_rise", 32'(a_drn), 32'd1);
        for (int k = 0; k < 8; k++) begin
            if (mid_start && k == 3) begin
                prot_m = 1'b1;
                a_nps  = 1'b0;
                tick();
                a_nps  = 1'b1;
                check("midstart_proterr", 32'(a_prot), 32'd1);
                check("midstart_draining", 32'(a_drn), 32'd1);
            end
            a_noc = 1'b0;
            tick();
            a_noc = 1'b1;
            check("drain_dout", 32'(a_dout), 32'(pg[k*4 +: 4]));
            check("drain_draining", 32'(a_drn), 32'(k < 7));
            check("drain_fillreq", 32'(a_fillreq), 32'((pages_q.size() + ((k < 7) ? 1 : 0)) < 2));
        end
        check("drain_underrun", 32'(a_und), 32'(und_m));
        check("drain_proterr", 32'(a_prot), 32'(prot_m));
    endtask

    initial begin
        nrst = 1'b0;
        a_nen = 1'b0; a_nwr = 1'b1; a_wraddr = 5'd0; a_wrdata = 1'b0;
        a_nfd = 1'b1; a_nps = 1'b1; a_noc = 1'b1;
        b_nen = 1'b0; b_nwr = 1'b1; b_wraddr = 12'd0; b_wrdata = 1'b0;
        b_nfd = 1'b1; b_nps = 1'b1; b_noc = 1'b1;
        und_m = 1'b0; prot_m = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_fillreq", 32'(a_fillreq), 32'd0);
        check("rst_dout", 32'(a_dout), 32'd0);
        check("rst_draining", 32'(a_drn), 32'd0);
        check("rst_underrun", 32'(a_und), 32'd0);
        check("rst_proterr", 32'(a_prot), 32'd0);
        check("rst_b_fillreq", 32'(b_fillreq), 32'd0);
        nrst = 1'b1;
        tick();
        check("release_fillreq", 32'(a_fillreq), 32'd1);
        check("release_b_fillreq", 32'(b_fillreq), 32'd1);

        // Basic alternating pattern: bit (idx^ch)&1
        for (int i = 0; i < 32; i++) begin
            pg_v[i] = 1'(((i / 4) ^ (i % 4)) & 1);
        end
        a_write_page(pg_v);
        a_fill_done(pg_v);
        a_drain(1'b0);

        // Ping-pong: fill both banks, drain one, then refill while draining the other
        p_new = $urandom; a_write_page(p_new); a_fill_done(p_new);
        p_new = $urandom; a_write_page(p_new); a_fill_done(p_new);
        a_drain(1'b0);
        drain_pg = pages_q.pop_front();
        p_new    = $urandom;
        a_nps = 1'b0; tick(); a_nps = 1'b1;
        check("pp_drain_rise", 32'(a_drn), 32'd1);
        for (int t = 0; t < 32; t++) begin
            a_nwr    = 1'b0;
            a_wraddr = 5'(t);
            a_wrdata = p_new[t];
            a_noc    = (t % 4 == 3) ? 1'b0 : 1'b1;
            a_nfd    = (t == 31) ? 1'b0 : 1'b1;
            tick();
            if (t % 4 == 3) begin
                check("pp_dout", 32'(a_dout), 32'(drain_pg[(t / 4) * 4 +: 4]));
            end
        end
        a_nwr = 1'b1; a_noc = 1'b1; a_nfd = 1'b1;
        pages_q.push_back(p_new);
        check("pp_end_draining", 32'(a_drn), 32'd0);
        check("pp_end_fillreq", 32'(a_fillreq), 32'd1);
        a_drain(1'b0);

        // Underrun with both banks empty, then a normal page
        a_nps = 1'b0; tick(); a_nps = 1'b1;
        und_m = 1'b1;
        check("ur_underrun", 32'(a_und), 32'd1);
        check("ur_draining", 32'(a_drn), 32'd0);
        a_noc = 1'b0; tick(); a_noc = 1'b1;
        check("ur_dout", 32'(a_dout), 32'd0);
        p_new = $urandom; a_write_page(p_new); a_fill_done(p_new);
        a_drain(1'b0);

        // Protocol errors: fill-done with both banks full, start mid-drain
        p_new = $urandom; a_write_page(p_new); a_fill_done(p_new);
        p_new = $urandom; a_write_page(p_new); a_fill_done(p_new);
        a_fill_done(32'hDEAD_BEEF);
        a_drain(1'b1);
        a_drain(1'b0);
        p_new = $urandom; a_write_page(p_new); a_fill_done(p_new);
        a_drain(1'b0);

        // Flush in the middle of a page
        p_new = $urandom; a_write_page(p_new); a_fill_done(p_new);
        drain_pg = pages_q.pop_front();
        a_nps = 1'b0; tick(); a_nps = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_noc = 1'b0; tick(); a_noc = 1'b1;
            check("fl_dout", 32'(a_dout), 32'(drain_pg[k*4 +: 4]));
        end
        a_noc = 1'b0; a_nen = 1'b1; tick(); a_noc = 1'b1;
        pages_q.delete();
        und_m = 1'b0; prot_m = 1'b0;
        check("fl_dout_idle", 32'(a_dout), 32'd0);
        check("fl_draining", 32'(a_drn), 32'd0);
        check("fl_fillreq", 32'(a_fillreq), 32'd0);
        check("fl_underrun", 32'(a_und), 32'd0);
        check("fl_proterr", 32'(a_prot), 32'd0);
        a_nen = 1'b0; tick();
        check("fl_fillreq_back", 32'(a_fillreq), 32'd1);
        p_new = $urandom; a_write_page(p_new); a_fill_done(p_new);
        a_drain(1'b0);

        // Single channel, full-length page; channel fields 1..3 must be ignored
        for (int i = 0; i < 584; i++) begin
            bstream[i] = 1'($urandom);
        end
        for (int i = 0; i < 584; i++) begin
            for (int ch = 0; ch < 4; ch++) begin
                b_nwr    = 1'b0;
                b_wraddr = {10'(i), 2'(ch)};
                b_wrdata = (ch == 0) ? bstream[i] : ~bstream[i];
                tick();
            end
        end
        b_nwr = 1'b1;
        b_nfd = 1'b0; tick(); b_nfd = 1'b1;
        check("b_fillreq_after_fill", 32'(b_fillreq), 32'd1);
        b_nps = 1'b0; tick(); b_nps = 1'b1;
        check("b_drain_rise", 32'(b_drn), 32'd1);
        b_noc = 1'b0;
        for (int i = 0; i < 585; i++) begin
            tick();
            check("b_dout", 32'(b_dout), (i < 584) ? 32'(bstream[i]) : 32'd0);
        end
        b_noc = 1'b1;
        check("b_draining_end", 32'(b_drn), 32'd0);
        check("b_underrun", 32'(b_und), 32'd0);
        check("b_proterr", 32'(b_prot), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
